// File: rtl/rs232_bridge_pkg.sv
// Shared constants and state encodings for the RS232 register bridge.
package rs232_bridge_pkg;

    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] RSP_WRITE = 8'h81;
    localparam logic [7:0] RSP_READ  = 8'h82;
    localparam logic [7:0] RSP_ERR   = 8'hEE;

    typedef enum logic [3:0] {
        IDLE,
        POP_HI,
        POP_LO,
        WAIT_RX,
        EXEC_WR,
        EXEC_RD,
        CAPTURE,
        RESP,
        PUSH_HI,
        PUSH_LO
    } state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_ROOM,
        PH_BUSY,
        PH_DRAIN
    } push_e;

endpackage

// File: rtl/rs232_reg_bridge_if.sv
// RS232 FIFO user port: receive-pop and transmit-push handshakes.
interface rs232_reg_bridge_if;

    logic [9:0] RxCount;
    logic [7:0] RxData;
    logic       Ack;
    logic       AckBusy;
    logic [7:0] TxData;
    logic       Send;
    logic       Busy;
    logic [9:0] TxCount;

    modport master (
        input  RxCount,
        input  RxData,
        input  AckBusy,
        input  Busy,
        input  TxCount,
        output Ack,
        output TxData,
        output Send
    );

    modport slave (
        output RxCount,
        output RxData,
        output AckBusy,
        output Busy,
        output TxCount,
        input  Ack,
        input  TxData,
        input  Send
    );

endinterface

// File: rtl/rs232_reg_bridge_push.sv
// Pushes one byte into the FIFO transmit side: waits for headroom,
// raises Send until Busy, then waits for Busy to fall and pulses done.
module rs232_push_handshake
    import rs232_bridge_pkg::*;
#(
    parameter logic [9:0] TxHeadroom = 10'd1016
) (
    input  logic       FIFO_Clk,
    input  logic       nReset,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic [9:0] TxCount,
    input  logic       Busy,
    output logic [7:0] TxData,
    output logic       Send,
    output logic       done
);

    push_e      st_q;
    push_e      st_d;
    logic [7:0] tx_q;
    logic [7:0] tx_d;
    logic       send_q;
    logic       send_d;
    logic       done_q;
    logic       done_d;

    always_comb begin
        st_d   = st_q;
        tx_d   = tx_q;
        send_d = send_q;
        done_d = 1'b0;
        unique case (st_q)
            PH_IDLE: begin
                if (start) begin
                    tx_d = byte_in;
                    st_d = PH_ROOM;
                end
            end
            PH_ROOM: begin
                if (TxCount < TxHeadroom) begin
                    send_d = 1'b1;
                    st_d   = PH_BUSY;
                end
            end
            PH_BUSY: begin
                if (Busy) begin
                    send_d = 1'b0;
                    st_d   = PH_DRAIN;
                end
            end
            PH_DRAIN: begin
                if (!Busy) begin
                    done_d = 1'b1;
                    st_d   = PH_IDLE;
                end
            end
            default: begin
                send_d = 1'b0;
                st_d   = PH_IDLE;
            end
        endcase
    end

    // TxData only changes on start, so it is stable across Send/Busy
    always_ff @(posedge FIFO_Clk or negedge nReset) begin
        if (!nReset) begin
            st_q   <= PH_IDLE;
            tx_q   <= 8'h00;
            send_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            tx_q   <= tx_d;
            send_q <= send_d;
            done_q <= done_d;
        end
    end

    assign TxData = tx_q;
    assign Send   = send_q;
    assign done   = done_q;

endmodule

// File: rtl/rs232_reg_bridge.sv
// RS232 FIFO client: pops command frames, runs them as 32-bit register
// reads/writes and pushes the response bytes back into the FIFO.
module rs232_reg_bridge
    import rs232_bridge_pkg::*;
#(
    parameter int                     TimeoutBits   = 24,
    parameter logic [TimeoutBits-1:0] TimeoutCycles = 24'd5_000_000,
    parameter logic [9:0]             TxHeadroom    = 10'd1016
) (
    input  logic               nReset,
    input  logic               FIFO_Clk,
    rs232_reg_bridge_if.master fifo,
    output logic [7:0]         RegAddress,
    output logic [31:0]        RegWriteData,
    output logic               RegWrite,
    output logic               RegRead,
    input  logic [31:0]        RegReadData,
    output logic               FrameError
);

    localparam logic [TimeoutBits-1:0] TO_ONE = TimeoutBits'(1);

    state_e                 state_q;
    state_e                 state_d;
    logic [2:0]             idx_q;
    logic [2:0]             idx_d;
    logic                   rd_op_q;
    logic                   rd_op_d;
    logic [7:0]             byte_q;
    logic [7:0]             byte_d;
    logic [TimeoutBits-1:0] to_q;
    logic [TimeoutBits-1:0] to_d;
    logic                   ack_q;
    logic                   ack_d;
    logic [7:0]             addr_q;
    logic [7:0]             addr_d;
    logic [31:0]            wdata_q;
    logic [31:0]            wdata_d;
    logic                   wr_q;
    logic                   wr_d;
    logic                   rd_q;
    logic                   rd_d;
    logic                   fe_q;
    logic                   fe_d;
    logic [39:0]            resp_q;
    logic [39:0]            resp_d;
    logic [2:0]             rcnt_q;
    logic [2:0]             rcnt_d;
    logic [1:0]             lane;
    logic                   push_start;
    logic                   push_done;
    logic [7:0]             tx_data;
    logic                   send;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rd_op_d    = rd_op_q;
        byte_d     = byte_q;
        to_d       = to_q;
        ack_d      = ack_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        fe_d       = 1'b0;
        resp_d     = resp_q;
        rcnt_d     = rcnt_q;
        push_start = 1'b0;
        lane       = idx_q[1:0] - 2'd2;
        unique case (state_q)
            IDLE: begin
                idx_d = 3'd0;
                to_d  = '0;
                if (fifo.RxCount != 10'd0) begin
                    byte_d  = fifo.RxData;
                    ack_d   = 1'b1;
                    state_d = POP_HI;
                end
            end
            WAIT_RX: begin
                // A waiting byte always beats an expiring timeout
                if (fifo.RxCount != 10'd0) begin
                    byte_d  = fifo.RxData;
                    ack_d   = 1'b1;
                    state_d = POP_HI;
                end else if (idx_q != 3'd0) begin
                    to_d = to_q + TO_ONE;
                    if (to_d == TimeoutCycles) begin
                        fe_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            POP_HI: begin
                if (fifo.AckBusy) begin
                    ack_d   = 1'b0;
                    state_d = POP_LO;
                end
            end
            POP_LO: begin
                if (!fifo.AckBusy) begin
                    to_d    = '0;
                    idx_d   = idx_q + 3'd1;
                    state_d = WAIT_RX;
                    if (idx_q == 3'd0) begin
                        if (byte_q == OP_READ) begin
                            rd_op_d = 1'b1;
                        end else if (byte_q == OP_WRITE) begin
                            rd_op_d = 1'b0;
                        end else begin
                            fe_d    = 1'b1;
                            resp_d  = {32'h0, RSP_ERR};
                            rcnt_d  = 3'd1;
                            state_d = RESP;
                        end
                    end else if (idx_q == 3'd1) begin
                        addr_d = byte_q;
                        if (rd_op_q) begin
                            rd_d    = 1'b1;
                            state_d = EXEC_RD;
                        end
                    end else begin
                        wdata_d[{lane, 3'b000} +: 8] = byte_q;
                        if (idx_q == 3'd5) begin
                            wr_d    = 1'b1;
                            state_d = EXEC_WR;
                        end
                    end
                end
            end
            EXEC_WR: begin
                resp_d  = {32'h0, RSP_WRITE};
                rcnt_d  = 3'd1;
                state_d = RESP;
            end
            EXEC_RD: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                resp_d  = {RegReadData, RSP_READ};
                rcnt_d  = 3'd5;
                state_d = RESP;
            end
            RESP: begin
                push_start = 1'b1;
                state_d    = PUSH_HI;
            end
            PUSH_HI: begin
                if (push_done) begin
                    resp_d  = {8'h00, resp_q[39:8]};
                    rcnt_d  = rcnt_q - 3'd1;
                    state_d = PUSH_LO;
                end
            end
            PUSH_LO: begin
                state_d = (rcnt_q == 3'd0) ? IDLE : RESP;
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge FIFO_Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            rd_op_q <= 1'b0;
            byte_q  <= 8'h00;
            to_q    <= '0;
            ack_q   <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 32'h0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            fe_q    <= 1'b0;
            resp_q  <= 40'h0;
            rcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rd_op_q <= rd_op_d;
            byte_q  <= byte_d;
            to_q    <= to_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fe_q    <= fe_d;
            resp_q  <= resp_d;
            rcnt_q  <= rcnt_d;
        end
    end

    rs232_push_handshake #(
        .TxHeadroom(TxHeadroom)
    ) u_push (
        .FIFO_Clk(FIFO_Clk),
        .nReset  (nReset),
        .start   (push_start),
        .byte_in (resp_q[7:0]),
        .TxCount (fifo.TxCount),
        .Busy    (fifo.Busy),
        .TxData  (tx_data),
        .Send    (send),
        .done    (push_done)
    );

    assign fifo.Ack     = ack_q;
    assign fifo.TxData  = tx_data;
    assign fifo.Send    = send;
    assign RegAddress   = addr_q;
    assign RegWriteData = wdata_q;
    assign RegWrite     = wr_q;
    assign RegRead      = rd_q;
    assign FrameError   = fe_q;

endmodule

// File: tb/tb_rs232_reg_bridge.sv
// Bench for rs232_reg_bridge: FIFO and register-file models plus a
// frame-level reference model of the command protocol.
module tb_rs232_reg_bridge;

    typedef logic [7:0] u8;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic [7:0]  RegAddress;
    logic [31:0] RegWriteData;
    logic        RegWrite;
    logic        RegRead;
    logic [31:0] RegReadData;
    logic        FrameError;

    u8           rxq[$];
    u8           txq[$];
    logic [31:0] bus_regs[256];
    logic [31:0] model_regs[256];
    int          wr_cnt;
    int          rd_cnt;
    int          fe_cnt;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  rd_addr;
    logic        rd_prev;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    rs232_reg_bridge_if fif ();

    rs232_reg_bridge #(
        .TimeoutBits  (24),
        .TimeoutCycles(24'd100),
        .TxHeadroom   (10'd1016)
    ) dut (
        .nReset      (nReset),
        .FIFO_Clk    (clk),
        .fifo        (fif),
        .RegAddress  (RegAddress),
        .RegWriteData(RegWriteData),
        .RegWrite    (RegWrite),
        .RegRead     (RegRead),
        .RegReadData (RegReadData),
        .FrameError  (FrameError)
    );

    // FIFO model: pop and push handshakes with random latencies
    initial begin
        int pst;
        int pdl;
        int sst;
        int sdl;
        pst = 0; pdl = 0; sst = 0; sdl = 0;
        fif.AckBusy = 1'b0;
        fif.Busy    = 1'b0;
        fif.RxCount = 10'd0;
        fif.RxData  = 8'h00;
        forever begin
            @(negedge clk);
            case (pst)
                0: if (fif.Ack === 1'b1) begin
                    pdl = int'($urandom_range(0, 2)); pst = 1;
                end
                1: if (pdl == 0) begin
                    if (rxq.size() != 0) void'(rxq.pop_front());
                    fif.AckBusy = 1'b1; pst = 2;
                end else pdl--;
                2: if (fif.Ack !== 1'b1) begin
                    pdl = int'($urandom_range(0, 2)); pst = 3;
                end
                3: if (pdl == 0) begin
                    fif.AckBusy = 1'b0; pst = 0;
                end else pdl--;
                default: pst = 0;
            endcase
            case (sst)
                0: if (fif.Send === 1'b1) begin
                    sdl = int'($urandom_range(0, 2)); sst = 1;
                end
                1: if (sdl == 0) begin
                    txq.push_back(fif.TxData);
                    fif.Busy = 1'b1; sst = 2;
                end else sdl--;
                2: if (fif.Send !== 1'b1) begin
                    sdl = int'($urandom_range(0, 2)); sst = 3;
                end
                3: if (sdl == 0) begin
                    fif.Busy = 1'b0; sst = 0;
                end else sdl--;
                default: sst = 0;
            endcase
            fif.RxCount = 10'(rxq.size());
            fif.RxData  = (rxq.size() != 0) ? rxq[0] : 8'h00;
        end
    end

    // Register file: read data is valid only in the cycle after RegRead
    initial begin
        wr_cnt = 0; rd_cnt = 0; fe_cnt = 0;
        wr_addr = 8'h00; wr_data = 32'h0; rd_addr = 8'h00;
        rd_prev = 1'b0;
        RegReadData = 32'h0;
        forever begin
            @(negedge clk);
            RegReadData = rd_prev ? bus_regs[rd_addr] : $urandom;
            rd_prev = RegRead;
            if (RegRead === 1'b1) begin
                rd_cnt++;
                rd_addr = RegAddress;
            end
            if (RegWrite === 1'b1) begin
                wr_cnt++;
                wr_addr = RegAddress;
                wr_data = RegWriteData;
                bus_regs[RegAddress] = RegWriteData;
            end
            if (FrameError === 1'b1) fe_cnt++;
        end
    end

    // Reference: interpret a byte stream as frames, produce responses
    task automatic model_stream(input u8 s[$], output u8 r[$]);
        int i;
        logic [7:0] a;
        logic [31:0] d;
        i = 0;
        r = {};
        while (i < s.size()) begin
            if (s[i] == 8'h01 && i + 5 < s.size()) begin
                a = s[i+1];
                d = {s[i+5], s[i+4], s[i+3], s[i+2]};
                model_regs[a] = d;
                r.push_back(8'h81);
                i += 6;
            end else if (s[i] == 8'h02 && i + 1 < s.size()) begin
                d = model_regs[s[i+1]];
                r.push_back(8'h82);
                for (int k = 0; k < 4; k++) r.push_back(d[8*k +: 8]);
                i += 2;
            end else begin
                r.push_back(8'hEE);
                i++;
            end
        end
    endtask

    task automatic gen_frame(input int kind, output u8 f[$]);
        logic [7:0] a;
        logic [31:0] d;
        logic [7:0] b;
        a = 8'($urandom_range(0, 7));
        d = $urandom;
        f = {};
        if (kind == 0) f = '{8'h01, a, d[7:0], d[15:8], d[23:16], d[31:24]};
        else if (kind == 1) f = '{8'h02, a};
        else begin
            b = 8'($urandom_range(3, 255));
            f.push_back(b);
        end
    endtask

    task automatic push_rx(input u8 f[$]);
        foreach (f[i]) rxq.push_back(f[i]);
    endtask

    task automatic wait_tx(input int n, output bit ok);
        int c;
        c = 0;
        while (txq.size() < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
        repeat (10) @(negedge clk);
        ok = (txq.size() == n);
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({fif.Ack, fif.Send, RegWrite, RegRead, FrameError} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_strobes got %b want 00000",
                     {fif.Ack, fif.Send, RegWrite, RegRead, FrameError});
        end
        n_cmp++;
        if (fif.TxData !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_txdata got %h want 00", fif.TxData);
        end
        n_cmp++;
        if (RegAddress !== 8'h00 || RegWriteData !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_regbus got %h/%h want 00/00000000",
                     RegAddress, RegWriteData);
        end
        nReset = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (fif.Ack !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_no_ack got %b want 0", fif.Ack);
        end
    endtask

    task automatic test_write();
        u8 f[$];
        u8 e[$];
        bit ok;
        int w0;
        int fe0;
        w0 = wr_cnt; fe0 = fe_cnt;
        f = '{8'h01, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        model_stream(f, e);
        txq.delete();
        push_rx(f);
        wait_tx(1, ok);
        n_cmp++;
        if (!ok || txq[0] !== 8'h81) begin
            n_bad++;
            $display("FAIL write_resp got %0d bytes first %h want 1 byte 81",
                     txq.size(), (txq.size() != 0) ? txq[0] : 8'hxx);
        end
        n_cmp++;
        if (wr_cnt - w0 != 1) begin
            n_bad++;
            $display("FAIL write_pulses got %0d want 1", wr_cnt - w0);
        end
        n_cmp++;
        if (wr_addr !== 8'h10 || wr_data !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL write_bus got %h/%h want 10/deadbeef", wr_addr, wr_data);
        end
        n_cmp++;
        if (fif.RxCount !== 10'd0 || fe_cnt != fe0) begin
            n_bad++;
            $display("FAIL write_idle got rx=%0d fe=%0d want rx=0 fe=0",
                     fif.RxCount, fe_cnt - fe0);
        end
    endtask

    task automatic test_read();
        u8 f[$];
        u8 e[$];
        bit ok;
        int r0;
        r0 = rd_cnt;
        bus_regs[8'h22] = 32'h12345678;
        model_regs[8'h22] = 32'h12345678;
        f = '{8'h02, 8'h22};
        model_stream(f, e);
        txq.delete();
        push_rx(f);
        wait_tx(5, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL read_len got %0d want 5", txq.size());
        end else foreach (e[i]) begin
            n_cmp++;
            if (txq[i] !== e[i]) begin
                n_bad++;
                $display("FAIL read_byte%0d got %h want %h", i, txq[i], e[i]);
            end
        end
        n_cmp++;
        if (rd_cnt - r0 != 1 || rd_addr !== 8'h22) begin
            n_bad++;
            $display("FAIL read_bus got %0d pulses addr %h want 1 addr 22",
                     rd_cnt - r0, rd_addr);
        end
    endtask

    task automatic test_bad_opcode();
        u8 f[$];
        u8 e[$];
        bit ok;
        int fe0;
        fe0 = fe_cnt;
        f = '{8'h55, 8'h02, 8'h00};
        model_stream(f, e);
        txq.delete();
        push_rx(f);
        wait_tx(6, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL badop_len got %0d want 6", txq.size());
        end else foreach (e[i]) begin
            n_cmp++;
            if (txq[i] !== e[i]) begin
                n_bad++;
                $display("FAIL badop_byte%0d got %h want %h", i, txq[i], e[i]);
            end
        end
        n_cmp++;
        if (fe_cnt - fe0 != 1) begin
            n_bad++;
            $display("FAIL badop_fe got %0d want 1", fe_cnt - fe0);
        end
    endtask

    task automatic test_timeout();
        u8 f[$];
        u8 e[$];
        bit ok;
        int w0;
        int fe0;
        int c;
        w0 = wr_cnt; fe0 = fe_cnt;
        txq.delete();
        f = '{8'h01, 8'h10, 8'hAA};
        push_rx(f);
        c = 0;
        while ((rxq.size() != 0 || fif.AckBusy !== 1'b0) && c < 500) begin
            @(negedge clk);
            c++;
        end
        c = 0;
        while (fe_cnt == fe0 && c < 400) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (c < 96 || c > 112) begin
            n_bad++;
            $display("FAIL timeout_delay got %0d cycles want 96..112", c);
        end
        repeat (30) @(negedge clk);
        n_cmp++;
        if (txq.size() != 0 || wr_cnt != w0 || fe_cnt - fe0 != 1) begin
            n_bad++;
            $display("FAIL timeout_silent got tx=%0d wr=%0d fe=%0d want 0/0/1",
                     txq.size(), wr_cnt - w0, fe_cnt - fe0);
        end
        gen_frame(0, f);
        model_stream(f, e);
        push_rx(f);
        wait_tx(1, ok);
        n_cmp++;
        if (!ok || txq[0] !== 8'h81 || wr_cnt - w0 != 1 || wr_addr !== f[1]) begin
            n_bad++;
            $display("FAIL timeout_recover got tx=%0d wr=%0d addr=%h want 1/1/%h",
                     txq.size(), wr_cnt - w0, wr_addr, f[1]);
        end
        n_cmp++;
        if (wr_data !== {f[5], f[4], f[3], f[2]}) begin
            n_bad++;
            $display("FAIL timeout_recover_data got %h want %h",
                     wr_data, {f[5], f[4], f[3], f[2]});
        end
    endtask

    task automatic test_headroom();
        u8 f[$];
        u8 e[$];
        bit ok;
        int r0;
        int sends;
        r0 = rd_cnt;
        sends = 0;
        fif.TxCount = 10'd1016;
        gen_frame(1, f);
        model_stream(f, e);
        txq.delete();
        push_rx(f);
        repeat (80) begin
            @(negedge clk);
            if (fif.Send === 1'b1) sends++;
        end
        n_cmp++;
        if (sends != 0 || rd_cnt - r0 != 1) begin
            n_bad++;
            $display("FAIL headroom_hold got sends=%0d reads=%0d want 0/1",
                     sends, rd_cnt - r0);
        end
        fif.TxCount = 10'd1000;
        wait_tx(5, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL headroom_len got %0d want 5", txq.size());
        end else foreach (e[i]) begin
            n_cmp++;
            if (txq[i] !== e[i]) begin
                n_bad++;
                $display("FAIL headroom_byte%0d got %h want %h", i, txq[i], e[i]);
            end
        end
        fif.TxCount = 10'd0;
    endtask

    task automatic test_random();
        u8 f[$];
        u8 e[$];
        bit ok;
        int kind;
        int fe0;
        for (int n = 0; n < 12; n++) begin
            kind = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            gen_frame(kind, f);
            model_stream(f, e);
            fe0 = fe_cnt;
            txq.delete();
            push_rx(f);
            wait_tx(e.size(), ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL rand%0d_len got %0d want %0d", n, txq.size(), e.size());
            end else foreach (e[i]) begin
                n_cmp++;
                if (txq[i] !== e[i]) begin
                    n_bad++;
                    $display("FAIL rand%0d_byte%0d got %h want %h", n, i, txq[i], e[i]);
                end
            end
            n_cmp++;
            if (fe_cnt - fe0 != ((kind == 2) ? 1 : 0)) begin
                n_bad++;
                $display("FAIL rand%0d_fe got %0d want %0d",
                         n, fe_cnt - fe0, (kind == 2) ? 1 : 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        u8 f[$];
        u8 s[$];
        u8 e[$];
        bit ok;
        int w0;
        int nw;
        w0 = wr_cnt; nw = 0;
        s = {};
        for (int n = 0; n < 6; n++) begin
            gen_frame(n % 2, f);
            if (n % 2 == 0) nw++;
            foreach (f[i]) s.push_back(f[i]);
        end
        model_stream(s, e);
        txq.delete();
        push_rx(s);
        wait_tx(e.size(), ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL b2b_len got %0d want %0d", txq.size(), e.size());
        end else foreach (e[i]) begin
            n_cmp++;
            if (txq[i] !== e[i]) begin
                n_bad++;
                $display("FAIL b2b_byte%0d got %h want %h", i, txq[i], e[i]);
            end
        end
        n_cmp++;
        if (wr_cnt - w0 != nw) begin
            n_bad++;
            $display("FAIL b2b_writes got %0d want %0d", wr_cnt - w0, nw);
        end
    endtask

    task automatic test_reset_mid();
        u8 f[$];
        u8 e[$];
        bit ok;
        int c;
        int w0;
        f = '{8'h02, 8'h03};
        txq.delete();
        push_rx(f);
        c = 0;
        while (fif.Send !== 1'b1 && c < 500) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (fif.Send !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_send got %b want 1", fif.Send);
        end
        #1 nReset = 1'b0;
        #1;
        n_cmp++;
        if ({fif.Send, fif.Ack, RegWrite, RegRead, FrameError} !== 5'b0 ||
            fif.TxData !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_async got %b txd %h want 00000 txd 00",
                     {fif.Send, fif.Ack, RegWrite, RegRead, FrameError}, fif.TxData);
        end
        repeat (10) @(negedge clk);
        rxq.delete();
        txq.delete();
        nReset = 1'b1;
        repeat (3) @(negedge clk);
        w0 = wr_cnt;
        gen_frame(0, f);
        model_stream(f, e);
        push_rx(f);
        wait_tx(1, ok);
        n_cmp++;
        if (!ok || txq[0] !== 8'h81 || wr_cnt - w0 != 1 || wr_addr !== f[1]) begin
            n_bad++;
            $display("FAIL midrst_recover got tx=%0d wr=%0d addr=%h want 1/1/%h",
                     txq.size(), wr_cnt - w0, wr_addr, f[1]);
        end
    endtask

    initial begin
        logic [31:0] r;
        fif.TxCount = 10'd0;
        for (int i = 0; i < 256; i++) begin
            r = $urandom;
            bus_regs[i] = r;
            model_regs[i] = r;
        end
        test_reset();
        test_write();
        test_read();
        test_bad_opcode();
        test_timeout();
        test_headroom();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
